// File: rtl/processing_element_pkg.sv
// Shared accelerator constants: activation/weight width and derived partial-sum width.
package processing_element_pkg;

  // Default activation / weight width for the matrix engine.
  localparam int PE_WIDTH = 8;

  // Partial sums carry a full product, so they are twice the operand width.
  function automatic int psum_width(input int w);
    return 2 * w;
  endfunction

  localparam int PE_PSUM_WIDTH = psum_width(PE_WIDTH);

endpackage

// File: rtl/processing_element_pe_mac.sv
// Combinational multiply-accumulate: y = a*b + c, unsigned, wrapping at 2*WIDTH bits.
module pe_mac
  import processing_element_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH
) (
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [psum_width(WIDTH)-1:0] c,
  output logic [psum_width(WIDTH)-1:0] y
);

  localparam int PW = psum_width(WIDTH);

  logic [PW-1:0] prod;

  // Full-width product; the add drops the carry so overflow wraps.
  always_comb begin
    prod = PW'(a) * PW'(b);
    y    = prod + c;
  end

endmodule

// File: rtl/processing_element.sv
// Weight-stationary systolic MAC cell: stores one weight, forwards activations right,
// and passes the registered partial sum down.
module processing_element
  import processing_element_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Load,
  input  logic [WIDTH-1:0]             Weight,
  input  logic [WIDTH-1:0]             Input,
  input  logic [psum_width(WIDTH)-1:0] PsumIn,
  output logic [WIDTH-1:0]             ToRight,
  output logic [WIDTH-1:0]             ToDown,
  output logic [psum_width(WIDTH)-1:0] PsumOut
);

  localparam int PW = psum_width(WIDTH);

  logic [WIDTH-1:0] w;
  logic [PW-1:0]    mac;

  // MAC always sees the weight held before the edge, so a load overlapping
  // a compute only takes effect on the following cycle.
  pe_mac #(.WIDTH(WIDTH)) u_mac (
    .a (w),
    .b (Input),
    .c (PsumIn),
    .y (mac)
  );

  // Weight shift chain, activation forward and partial-sum pipeline registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w       <= '0;
      ToRight <= '0;
      PsumOut <= '0;
    end else begin
      if (Load) w <= Weight;
      ToRight <= Input;
      PsumOut <= mac;
    end
  end

  // Stored weight feeds the cell below directly from its register.
  assign ToDown = w;

endmodule

// File: tb/tb_processing_element.sv
// Directed bench for processing_element with hand-computed expected values.
module tb_processing_element;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          CLK;
  logic          RST;
  logic          Load;
  logic [W-1:0]  Weight;
  logic [W-1:0]  Input;
  logic [PW-1:0] PsumIn;
  logic [W-1:0]  ToRight;
  logic [W-1:0]  ToDown;
  logic [PW-1:0] PsumOut;

  int n_cmp = 0;
  int n_err = 0;

  processing_element #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Load    (Load),
    .Weight  (Weight),
    .Input   (Input),
    .PsumIn  (PsumIn),
    .ToRight (ToRight),
    .ToDown  (ToDown),
    .PsumOut (PsumOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic ld, input logic [W-1:0] wt, input logic [W-1:0] a,
                      input logic [PW-1:0] p);
    @(negedge CLK);
    Load = ld; Weight = wt; Input = a; PsumIn = p;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [W-1:0] r, input logic [W-1:0] d,
                      input logic [PW-1:0] p);
    chk({tag, ".ToRight"}, PW'(ToRight), PW'(r));
    chk({tag, ".ToDown"},  PW'(ToDown),  PW'(d));
    chk({tag, ".PsumOut"}, PsumOut,      p);
  endtask

  initial begin
    // Reset with random inputs: outputs must read 0 before any clock edge.
    RST = 1'b1; Load = 1'b1;
    Weight = W'($urandom); Input = W'($urandom); PsumIn = PW'($urandom);
    #1;
    chk3("reset_immediate", '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'($urandom), W'($urandom), PW'($urandom));
      chk3("reset_hold", '0, '0, '0);
    end
    @(negedge CLK);
    RST = 1'b0; Load = 1'b0; Weight = '0; Input = '0; PsumIn = '0;

    // Load weight 5; MAC uses old weight 0.
    step(1'b1, 8'd5, 8'd0, 16'd0);
    chk3("load5", 8'd0, 8'd5, 16'd0);

    // Compute 15 + 5*6.
    step(1'b0, 8'd0, 8'd6, 16'd15);
    chk3("compute45", 8'd6, 8'd5, 16'd45);

    // Weight input changes without Load: stored weight still 5.
    step(1'b0, 8'd9, 8'd2, 16'd0);
    chk3("hold", 8'd2, 8'd5, 16'd10);

    // Load and compute on the same edge: MAC uses old weight 5.
    step(1'b1, 8'd3, 8'd4, 16'd1);
    chk3("overlap", 8'd4, 8'd3, 16'd21);
    step(1'b0, 8'd3, 8'd4, 16'd1);
    chk3("overlap_next", 8'd4, 8'd3, 16'd13);

    // Mid-range vector: 1000 + 200*100.
    step(1'b1, 8'd200, 8'd0, 16'd7);
    chk3("load200", 8'd0, 8'd200, 16'd7);
    step(1'b0, 8'd0, 8'd100, 16'd1000);
    chk3("compute21000", 8'd100, 8'd200, 16'd21000);

    // Wrap-around: 255*255 + 0xFFFF mod 2^16.
    step(1'b1, 8'd255, 8'd0, 16'd0);
    chk3("load255", 8'd0, 8'd255, 16'd0);
    step(1'b0, 8'd0, 8'd255, 16'hFFFF);
    chk3("wrap", 8'd255, 8'd255, 16'hFE00);

    // Streaming, then a reset pulse between edges.
    step(1'b0, 8'd0, 8'd7, 16'd100);
    chk3("stream", 8'd7, 8'd255, 16'd1885);
    #2;
    RST = 1'b1;
    #1;
    chk3("midreset_immediate", '0, '0, '0);
    RST = 1'b0;
    // Stored weight is 0 now, so PsumOut must simply pass PsumIn.
    step(1'b0, 8'd0, 8'd9, 16'd1234);
    chk3("after_reset", 8'd9, 8'd0, 16'd1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
